// File: rtl/lint_mem_responder_pkg.sv
// Shared constants, state type and address helper
// for the LINT memory responder.
package lint_mem_responder_pkg;

  localparam logic [31:0] ERR_PATTERN = 32'hBADA_CCE5;

  localparam logic OPC_OK  = 1'b0;
  localparam logic OPC_ERR = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Word index of a byte offset; sub-word bits are dropped.
  function automatic logic [63:0] addr_to_idx(
    input logic [63:0] offset,
    input int unsigned shift
  );
    return offset >> shift;
  endfunction

endpackage

// File: rtl/lint_mem_responder_if.sv
// LINT (XBAR_TCDM_BUS) request/response bundle
// with initiator and responder views.
interface lint_mem_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                    req;
  logic [ADDR_WIDTH-1:0]   add;
  logic                    wen;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] be;
  logic                    gnt;
  logic                    r_valid;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_opc;

  modport master (
    output req, add, wen, wdata, be,
    input  gnt, r_valid, r_rdata, r_opc
  );

  modport slave (
    input  req, add, wen, wdata, be,
    output gnt, r_valid, r_rdata, r_opc
  );

endinterface

// File: rtl/lint_mem_array.sv
// Flop-based word memory: byte-enabled write port,
// asynchronous read port, async clear to zero.
module lint_mem_array #(
  parameter int unsigned NUM_WORDS  = 64,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDXW = $clog2(NUM_WORDS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [IDXW-1:0]         widx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [IDXW-1:0]         ridx,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int k = 0; k < BYTES; k++) begin
        if (be[k]) begin
          mem[widx][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/lint_mem_responder.sv
// LINT responder backed by a flop word memory,
// with optional grant wait states.
module lint_mem_responder
  import lint_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR =
    ADDR_WIDTH'(32'h1A11_0000),
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic clk_i,
  input logic rst_ni,
  lint_mem_responder_if.slave bus
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned SHIFT = $clog2(BYTES);
  localparam int unsigned IDXW  = $clog2(NUM_WORDS);
  localparam int unsigned SPAN  = NUM_WORDS * BYTES;

  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  localparam logic [DATA_WIDTH-1:0] ERR_DATA =
    DATA_WIDTH'(ERR_PATTERN);

  state_e                state;
  logic [3:0]            cnt;
  logic                  gnt;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_range;
  logic [IDXW-1:0]       idx;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_opc;

  // Offset wraps, so addresses below the base fall out of range.
  assign offset   = bus.add - BASE_ADDR;
  assign in_range = 64'(offset) < 64'(SPAN);
  assign idx      = IDXW'(addr_to_idx(64'(offset), SHIFT));

  assign gnt = (WAIT_CYCLES == 0) ? bus.req :
    (bus.req && (state == WAIT) && (cnt == 4'd0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (bus.req && (WAIT_CYCLES != 0)) begin
            state <= WAIT;
            cnt   <= CNT_INIT;
          end
        end
        (state == WAIT): begin
          if (!bus.req || (cnt == 4'd0)) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_we = gnt && !bus.wen && in_range;

  lint_mem_array #(
    .NUM_WORDS  (NUM_WORDS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDXW       (IDXW)
  ) u_array (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .we    (mem_we),
    .widx  (idx),
    .wdata (bus.wdata),
    .be    (bus.be),
    .ridx  (idx),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_rdata <= '0;
      r_opc   <= OPC_OK;
    end else begin
      r_valid <= gnt;
      if (gnt) begin
        if (!in_range) begin
          r_rdata <= ERR_DATA;
          r_opc   <= OPC_ERR;
        end else if (bus.wen) begin
          r_rdata <= mem_rdata;
          r_opc   <= OPC_OK;
        end else begin
          r_rdata <= '0;
          r_opc   <= OPC_OK;
        end
      end
    end
  end

  assign bus.gnt     = gnt;
  assign bus.r_valid = r_valid;
  assign bus.r_rdata = r_rdata;
  assign bus.r_opc   = r_opc;

endmodule
